// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory read port, redirect and decode-side handshake.
// Pure wiring, no latency of its own.
// Backpressure is carried by out_ready; the memory side has none.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_npc;
    logic [31:0] PC;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, out_valid, out_ir, out_npc, PC,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    // Memory / decode / write-back side
    modport slave (
        input  imem_req, imem_addr, out_valid, out_ir, out_npc, PC,
        output imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch with a DEPTH-entry prefetch queue in front of IF/ID.
// Latency: request to out_valid is 2 cycles, no bypass; 1 instr/cycle sustained.
// Backpressure: credit counts queued + in-flight - popping; requests stop when that reaches DEPTH.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   ir_mem [DEPTH];

    logic          head_vld;
    logic          pop;
    logic          enq;
    logic          issue;
    logic [PW+1:0] occ;

    assign head_vld = (count != '0);
    assign pop      = head_vld & bus.out_ready;
    // The in-flight word is dropped on redirect, so it never lands in the queue.
    assign enq      = inflight & ~bus.redirect;
    // Occupancy after this edge if nothing new were issued; pop frees a slot this cycle.
    assign occ      = (PW+2)'(count) + (PW+2)'(inflight) - (PW+2)'(pop);
    assign issue    = rst & ~bus.redirect & (occ < DEPTH_W);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = head_vld;
    assign bus.out_ir    = head_vld ? ir_mem[rd_ptr] : 32'h0;
    assign bus.PC        = head_vld ? pc_mem[rd_ptr] : 32'h0;
    assign bus.out_npc   = head_vld ? (pc_mem[rd_ptr] + 32'd4) : 32'h0;

    // Fetch PC, in-flight tracking, queue pointers and occupancy; redirect wins over everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
                inflight    <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(enq) - (PW+1)'(pop);
        end
    end

    // Queue storage; contents are only visible through the valid-gated outputs, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr] <= inflight_pc;
            ir_mem[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: fixed vector table from reset, directed corner sequences,
// and a randomized run compared cycle by cycle against a queue-based reference model.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if bus();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    // Synchronous instruction memory: word for the address presented this cycle arrives next cycle.
    always @(posedge clk) bus.imem_rdata <= word_at(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_if_pc;
    bit          m_if;

    task automatic model_reset();
        mq.delete();
        m_fetch_pc = RESET_PC;
        m_if_pc    = RESET_PC;
        m_if       = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against model, advance model across the edge.
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit          ev, epop, ereq;
        logic [31:0] epc, eir, enpc;
        ent_t        dropped;
        @(negedge clk);
        bus.out_ready   = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        #1;
        ev   = (mq.size() != 0);
        epop = ev && rdy;
        ereq = !redir && ((mq.size() + int'(m_if) - int'(epop)) < DEPTH);
        epc  = ev ? mq[0].pc : 32'h0;
        eir  = ev ? mq[0].ir : 32'h0;
        enpc = ev ? (mq[0].pc + 32'd4) : 32'h0;
        check("out_valid", 32'(bus.out_valid), 32'(ev));
        check("PC", bus.PC, epc);
        check("out_ir", bus.out_ir, eir);
        check("out_npc", bus.out_npc, enpc);
        check("imem_req", 32'(bus.imem_req), 32'(ereq));
        check("imem_addr", bus.imem_addr, m_fetch_pc);
        check("no_overflow", 32'(dut.count <= DEPTH), 32'd1);
        if (epop) dropped = mq.pop_front();
        if (redir) begin
            mq.delete();
            m_fetch_pc = rpc;
            m_if       = 1'b0;
        end else begin
            if (m_if) mq.push_back('{pc: m_if_pc, ir: word_at(m_if_pc)});
            if (ereq) begin
                m_if_pc    = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_if       = 1'b1;
            end else begin
                m_if = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_imem_addr"}, bus.imem_addr, RESET_PC);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_ir"}, bus.out_ir, 32'h0);
        check({tag, "_out_npc"}, bus.out_npc, 32'h0);
        check({tag, "_PC"}, bus.PC, 32'h0);
    endtask

    // Hold reset for two edges, check reset outputs, release mid high phase so the next
    // low phase is cycle 0.
    task automatic do_reset();
        rst             = 1'b0;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
    endtask

    // ---------------- fixed vector table ----------------
    typedef struct {
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;
        bit          v;
        logic [31:0] pc;
        bit          req;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Backpressure from reset, release, then redirect with 3 queued + 1 in flight.
        tbl[0]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h00};
        tbl[1]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h04};
        tbl[2]  = '{0, 0, 32'h0,   1, 32'h0,   1, 32'h08};
        tbl[3]  = '{0, 0, 32'h0,   1, 32'h0,   1, 32'h0C};
        tbl[4]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h10};
        tbl[5]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h10};
        tbl[6]  = '{1, 0, 32'h0,   1, 32'h0,   1, 32'h10};
        tbl[7]  = '{1, 0, 32'h0,   1, 32'h4,   1, 32'h14};
        tbl[8]  = '{1, 0, 32'h0,   1, 32'h8,   1, 32'h18};
        tbl[9]  = '{1, 0, 32'h0,   1, 32'hC,   1, 32'h1C};
        tbl[10] = '{1, 0, 32'h0,   1, 32'h10,  1, 32'h20};
        tbl[11] = '{0, 1, 32'h100, 1, 32'h14,  0, 32'h24};
        tbl[12] = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h100};
        tbl[13] = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h104};
        tbl[14] = '{0, 0, 32'h0,   1, 32'h100, 1, 32'h108};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.out_ready   = tbl[i].rdy;
            bus.redirect    = tbl[i].redir;
            bus.redirect_pc = tbl[i].rpc;
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d_PC", i), bus.PC, tbl[i].v ? tbl[i].pc : 32'h0);
            check($sformatf("tbl%0d_npc", i), bus.out_npc, tbl[i].v ? tbl[i].pc + 32'd4 : 32'h0);
            check($sformatf("tbl%0d_ir", i), bus.out_ir, tbl[i].v ? word_at(tbl[i].pc) : 32'h0);
            check($sformatf("tbl%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].req));
            check($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].addr);
        end

        // Streaming from reset with out_ready high.
        do_reset();
        repeat (10) cycle(1, 0, 32'h0);

        // Full queue, redirect in the same cycle as a pop, then resume at the new PC.
        do_reset();
        repeat (6) cycle(0, 0, 32'h0);
        cycle(1, 1, 32'h200);
        repeat (8) cycle(1, 0, 32'h0);

        // Redirect near the top of the address space: PCs wrap to zero.
        cycle(1, 1, 32'hFFFF_FFF8);
        repeat (8) cycle(1, 0, 32'h0);

        // Asynchronous reset with two entries queued: outputs clear before any edge.
        do_reset();
        repeat (3) cycle(0, 0, 32'h0);
        check("pre_arst_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        repeat (8) cycle(1, 0, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            bit          r_rdy, r_redir;
            logic [31:0] r_pc;
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_redir = ($urandom_range(0, 15) == 0);
            r_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            cycle(r_rdy, r_redir, r_pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
